// File: rtl/ray_dispatch_scheduler.sv
// Frame sequencer for the ray-march pipeline: raster coordinate issue, credit-bounded
// in-flight tracking, frame-boundary config shadowing. Optional counters: RAY_SCHED_PERF_EN.
module ray_dispatch_scheduler #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int FRAC_BITS    = 21,
    parameter int MAX_INFLIGHT = 16,
    parameter int CFG_W        = 256,
    localparam int IW          = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic             out_stream_aclk,
    input  logic             periph_reset,
    input  logic             enable,
    input  logic [CFG_W-1:0] cfg_in,
    input  logic             cfg_update,
    output logic [CFG_W-1:0] cfg_out,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [31:0]      screen_x,
    output logic [31:0]      screen_y,
    output logic             issue_sof,
    output logic             issue_eol,
    input  logic             retire,
    output logic [IW-1:0]    inflight,
    output logic             busy,
    output logic             frame_done,
    output logic             retire_err
`ifdef RAY_SCHED_PERF_EN
    ,
    output logic [31:0]      frame_cycles,
    output logic [31:0]      stall_credit,
    output logic [31:0]      stall_ready
`endif
);

    localparam int XW = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
    localparam int YW = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [IW-1:0]    infl_q, infl_d;
    logic             first_q, first_d;
    logic             pend_q, pend_d;
    logic [CFG_W-1:0] cfg_q, cfg_d;
    logic             valid_q, valid_d;
    logic [31:0]      sx_q, sx_d;
    logic [31:0]      sy_q, sy_d;
    logic             sof_q, sof_d;
    logic             eol_q, eol_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             xfer_s;
    logic             last_x_s;
    logic             last_y_s;

    // Next-state logic: FSM, raster indices, credit count, config shadow, output registers.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        infl_d   = infl_q;
        first_d  = first_q;
        pend_d   = pend_q | cfg_update;
        cfg_d    = cfg_q;
        err_d    = err_q;
        done_d   = 1'b0;
        xfer_s   = valid_q & issue_ready;
        last_x_s = (x_q == XW'(SCREEN_W - 1));
        last_y_s = (y_q == YW'(SCREEN_H - 1));

        case ({xfer_s, retire})
            2'b10: infl_d = infl_q + IW'(1);
            2'b01: begin
                if (infl_q == {IW{1'b0}}) begin
                    err_d = 1'b1;
                end else begin
                    infl_d = infl_q - IW'(1);
                end
            end
            default: infl_d = infl_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // An update landing in the capture cycle stays pending for the next frame.
                if (pend_q || first_q) begin
                    cfg_d   = cfg_in;
                    pend_d  = cfg_update;
                    first_d = 1'b0;
                end else begin
                    cfg_d = cfg_q;
                end
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (xfer_s) begin
                    if (last_x_s) begin
                        x_d = {XW{1'b0}};
                        if (last_y_s) begin
                            y_d     = {YW{1'b0}};
                            state_d = ST_DRAIN;
                        end else begin
                            y_d = y_q + YW'(1);
                        end
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end else begin
                    x_d = x_q;
                end
            end
            ST_DRAIN: begin
                if (infl_d == {IW{1'b0}}) begin
                    done_d  = 1'b1;
                    state_d = enable ? ST_LOAD : ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are computed from next state so they are registered yet cycle-accurate.
        valid_d = (state_d == ST_ISSUE) && (infl_d < IW'(MAX_INFLIGHT));
        sx_d    = 32'(x_d) << FRAC_BITS;
        sy_d    = 32'(y_d) << FRAC_BITS;
        sof_d   = (state_d == ST_ISSUE) && (x_d == {XW{1'b0}}) && (y_d == {YW{1'b0}});
        eol_d   = (state_d == ST_ISSUE) && (x_d == XW'(SCREEN_W - 1));
        busy_d  = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
        if (periph_reset) begin
            state_q <= ST_IDLE;
            x_q     <= {XW{1'b0}};
            y_q     <= {YW{1'b0}};
            infl_q  <= {IW{1'b0}};
            first_q <= 1'b1;
            pend_q  <= 1'b0;
            cfg_q   <= {CFG_W{1'b0}};
            valid_q <= 1'b0;
            sx_q    <= 32'd0;
            sy_q    <= 32'd0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            infl_q  <= infl_d;
            first_q <= first_d;
            pend_q  <= pend_d;
            cfg_q   <= cfg_d;
            valid_q <= valid_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cfg_out     = cfg_q;
    assign issue_valid = valid_q;
    assign screen_x    = sx_q;
    assign screen_y    = sy_q;
    assign issue_sof   = sof_q;
    assign issue_eol   = eol_q;
    assign inflight    = infl_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign retire_err  = err_q;

`ifdef RAY_SCHED_PERF_EN
    logic [31:0] fcyc_q, scred_q, srdy_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Restarting in LOAD keeps the previous frame's totals visible alongside frame_done.
    always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
        if (periph_reset) begin
            fcyc_q  <= 32'd0;
            scred_q <= 32'd0;
            srdy_q  <= 32'd0;
        end else if (state_q == ST_LOAD) begin
            fcyc_q  <= 32'd1;
            scred_q <= 32'd0;
            srdy_q  <= 32'd0;
        end else if (state_q != ST_IDLE) begin
            fcyc_q <= sat_inc(fcyc_q);
            if ((state_q == ST_ISSUE) && (infl_q == IW'(MAX_INFLIGHT))) begin
                scred_q <= sat_inc(scred_q);
            end else begin
                scred_q <= scred_q;
            end
            if ((state_q == ST_ISSUE) && valid_q && !issue_ready) begin
                srdy_q <= sat_inc(srdy_q);
            end else begin
                srdy_q <= srdy_q;
            end
        end else begin
            fcyc_q  <= fcyc_q;
            scred_q <= scred_q;
            srdy_q  <= srdy_q;
        end
    end

    assign frame_cycles = fcyc_q;
    assign stall_credit = scred_q;
    assign stall_ready  = srdy_q;
`endif

endmodule

// File: tb/tb_ray_dispatch_scheduler.sv
// Directed bench for ray_dispatch_scheduler on a 4x2 screen with 4 credits; pixel scoreboard queue.
module tb_ray_dispatch_scheduler;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int FB = 21;
    localparam int MI = 4;
    localparam int CW = 256;
    localparam int IW = $clog2(MI + 1);

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic        sof;
        logic        eol;
    } pix_t;

    logic          clk = 1'b0;
    logic          periph_reset;
    logic          enable;
    logic [CW-1:0] cfg_in;
    logic          cfg_update;
    logic [CW-1:0] cfg_out;
    logic          issue_valid;
    logic          issue_ready;
    logic [31:0]   screen_x;
    logic [31:0]   screen_y;
    logic          issue_sof;
    logic          issue_eol;
    logic          retire;
    logic [IW-1:0] inflight;
    logic          busy;
    logic          frame_done;
    logic          retire_err;

    pix_t          exp_q[$];
    int            ret_due[$];
    int            n_tests = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            n_xfer = 0;
    int            n_done = 0;
    int            m_inf = 0;
    int            base;
    logic          m_err = 1'b0;
    logic          frame_act = 1'b0;
    logic [CW-1:0] cfg_a = {8{32'hA5A5_0001}};
    logic [CW-1:0] cfg_b = {8{32'h5A5A_0002}};

    always #5 clk = ~clk;

    ray_dispatch_scheduler #(
        .SCREEN_W(W), .SCREEN_H(H), .FRAC_BITS(FB), .MAX_INFLIGHT(MI), .CFG_W(CW)
    ) dut (
        .out_stream_aclk(clk),
        .periph_reset(periph_reset),
        .enable(enable),
        .cfg_in(cfg_in),
        .cfg_update(cfg_update),
        .cfg_out(cfg_out),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .screen_x(screen_x),
        .screen_y(screen_y),
        .issue_sof(issue_sof),
        .issue_eol(issue_eol),
        .retire(retire),
        .inflight(inflight),
        .busy(busy),
        .frame_done(frame_done),
        .retire_err(retire_err)
    );

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame();
        pix_t p;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                p.x   = 32'(x) << FB;
                p.y   = 32'(y) << FB;
                p.sof = (x == 0) && (y == 0);
                p.eol = (x == W - 1);
                exp_q.push_back(p);
            end
        end
        frame_act = 1'b1;
    endtask

    function automatic logic due_ret();
        int d;
        if (ret_due.size() > 0 && ret_due[0] <= cyc) begin
            d = ret_due.pop_front();
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock: drive, score any transfer, update the model, then check post-edge outputs.
    task automatic step(input logic rdy, input logic ret);
        logic        xfer, hold, en_edge, exp_done;
        logic [31:0] hx, hy;
        pix_t        e;
        issue_ready = rdy;
        retire      = ret;
        en_edge     = enable;
        xfer        = issue_valid & rdy;
        hold        = issue_valid & ~rdy;
        hx          = screen_x;
        hy          = screen_y;
        if (xfer) begin
            n_xfer++;
            ret_due.push_back(cyc + 3);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            chk("pixel", {screen_x, screen_y, issue_sof, issue_eol}, e);
        end
        if (xfer && !ret) m_inf++;
        else if (!xfer && ret) begin
            if (m_inf == 0) m_err = 1'b1;
            else m_inf--;
        end
        @(posedge clk);
        #1;
        cyc++;
        retire     = 1'b0;
        cfg_update = 1'b0;
        chk("inflight", inflight, m_inf);
        chk("retire_err", retire_err, m_err);
        if (hold) begin
            chk("hold_x", screen_x, hx);
            chk("hold_y", screen_y, hy);
        end
        exp_done = frame_act && (exp_q.size() == 0) && (m_inf == 0);
        chk("frame_done", frame_done, exp_done);
        if (exp_done) begin
            frame_act = 1'b0;
            n_done++;
            if (en_edge) push_frame();
        end
    endtask

    initial begin
        periph_reset = 1'b1;
        enable       = 1'b0;
        cfg_in       = cfg_a;
        cfg_update   = 1'b0;
        issue_ready  = 1'b0;
        retire       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", issue_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_inflight", inflight, 0);
        chk("rst_cfg", cfg_out, 0);
        chk("rst_x", screen_x, 0);
        chk("rst_sof", issue_sof, 1'b0);
        chk("rst_done", frame_done, 1'b0);

        // Frame 1: latency, raster order, config held at A despite mid-frame update.
        periph_reset = 1'b0;
        enable       = 1'b1;
        push_frame();
        step(1'b1, 1'b0);
        chk("lat_load_valid", issue_valid, 1'b0);
        chk("lat_load_busy", busy, 1'b1);
        step(1'b1, 1'b0);
        chk("lat_issue_valid", issue_valid, 1'b1);
        chk("cfg_first", cfg_out, cfg_a);
        for (int k = 0; k < 60; k++) begin
            if (k == 2) begin
                cfg_in     = cfg_b;
                cfg_update = 1'b1;
            end
            step(1'b1, due_ret());
            if (n_done == 0) chk("cfg_hold_a", cfg_out, cfg_a);
            if (n_done == 1) break;
        end
        chk("f1_done", n_done, 1);
        chk("f1_xfers", n_xfer, 8);
        chk("cfg_a_at_load", cfg_out, cfg_a);
        step(1'b1, due_ret());
        chk("cfg_b_after_load", cfg_out, cfg_b);

        // Frame 2: credit limit, single-credit refill, simultaneous transfer+retire.
        ret_due.delete();
        base = n_xfer;
        repeat (8) step(1'b1, 1'b0);
        chk("credit_xfers", n_xfer - base, 4);
        chk("credit_inflight", inflight, MI);
        chk("credit_valid", issue_valid, 1'b0);
        step(1'b0, 1'b1);
        repeat (4) step(1'b1, 1'b0);
        chk("refill_xfers", n_xfer - base, 5);
        chk("refill_inflight", inflight, MI);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("two_valid", issue_valid, 1'b1);
        step(1'b1, 1'b1);
        chk("simul_inflight", inflight, 2);
        chk("simul_xfers", n_xfer - base, 6);

        // Finish frame 2 with random ready/retire after enable drops.
        enable = 1'b0;
        for (int k = 0; k < 300; k++) begin
            step(1'($urandom_range(0, 1)), (m_inf > 0) ? 1'($urandom_range(0, 1)) : 1'b0);
            if (n_done == 2) break;
        end
        chk("f2_done", n_done, 2);
        chk("f2_busy_low", busy, 1'b0);
        repeat (3) step(1'b1, 1'b0);
        chk("idle_valid", issue_valid, 1'b0);
        chk("idle_busy", busy, 1'b0);

        // Retire with nothing outstanding.
        step(1'b0, 1'b1);
        chk("err_set", retire_err, 1'b1);
        chk("err_inflight", inflight, 0);

        // Reset in the middle of ISSUE, then a clean frame from (0,0).
        ret_due.delete();
        enable = 1'b1;
        push_frame();
        repeat (5) step(1'b1, due_ret());
        periph_reset = 1'b1;
        #1;
        chk("arst_valid", issue_valid, 1'b0);
        chk("arst_inflight", inflight, 0);
        chk("arst_x", screen_x, 0);
        chk("arst_y", screen_y, 0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_err", retire_err, 1'b0);
        chk("arst_cfg", cfg_out, 0);
        exp_q.delete();
        ret_due.delete();
        m_inf     = 0;
        m_err     = 1'b0;
        frame_act = 1'b0;
        @(posedge clk);
        #1;
        periph_reset = 1'b0;
        push_frame();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("post_rst_sof", issue_sof, 1'b1);
        chk("post_rst_x", screen_x, 0);
        for (int k = 0; k < 60; k++) begin
            step(1'b1, due_ret());
            if (n_done == 3) break;
        end
        chk("f3_done", n_done, 3);
        enable = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ray_dispatch_scheduler.md
Name: ray_dispatch_scheduler

Overview:
- Frame-level sequencer for the ray-march pipeline. It issues per-pixel screen coordinates to the ray unit, and bounds in-flight rays with a credit counter so the packer never overflows.
- Latches camera/light configuration into a shadow register only at frame boundaries, so a frame never mixes two configurations.
- Sits between the AXI-Lite register file (config source) and the ray unit; it replaces free-running x/y counters.

Parameters:
- SCREEN_W, 640, pixels per line
- SCREEN_H, 480, lines per frame
- FRAC_BITS, 21, fractional bits of the screen_x/screen_y fixed-point output (1 pixel = 1<<FRAC_BITS)
- MAX_INFLIGHT, 16, maximum rays issued but not yet retired
- CFG_W, 256, width of the configuration bundle (8 x 32-bit registers)

Ports:
- out_stream_aclk  in  1  clock
- periph_reset  in  1  asynchronous, active-high reset
- enable  in  1  level; run frames continuously while high
- cfg_in  in  CFG_W  live register-file contents
- cfg_update  in  1  one-cycle pulse; new configuration written
- cfg_out  out  CFG_W  shadow configuration driving the ray unit
- issue_valid  out  1  coordinate valid
- issue_ready  in  1  ray unit accepts coordinate
- screen_x  out  32  pixel x, unsigned fixed-point, x_index<<FRAC_BITS
- screen_y  out  32  pixel y, unsigned fixed-point, y_index<<FRAC_BITS
- issue_sof  out  1  with issue_valid: pixel (0,0)
- issue_eol  out  1  with issue_valid: last pixel of line
- retire  in  1  one ray completed (ray unit valid_out accepted by packer)
- inflight  out  $clog2(MAX_INFLIGHT+1)  outstanding ray count
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse; last ray of frame retired
- retire_err  out  1  sticky; retire seen with inflight==0

Behaviour:
- Reset (async assert, released synchronously to out_stream_aclk):
  - state=IDLE, x_index=y_index=0, inflight=0.
  - cfg_out=0, cfg_pending=0.
  - All outputs 0.
- State machine IDLE -> LOAD -> ISSUE -> DRAIN -> (LOAD | IDLE):
  - IDLE: when enable=1, go to LOAD next cycle.
  - LOAD: one cycle. If cfg_pending or first frame since reset: cfg_out<=cfg_in and clear cfg_pending. Go to ISSUE.
  - ISSUE: issue_valid = (inflight < MAX_INFLIGHT). A transfer occurs when issue_valid & issue_ready.
    - On transfer, x_index increments. At x_index==SCREEN_W-1, x_index wraps to 0 and y_index increments.
    - After the transfer of (SCREEN_W-1, SCREEN_H-1), indices wrap to 0 and go to DRAIN.
  - DRAIN: issue_valid=0. When inflight==0 (including the cycle a final retire brings it to 0), pulse frame_done.
    - Then go to LOAD if enable=1, else IDLE.
- screen_x, screen_y, issue_sof and issue_eol are registered from the indices. They are stable while issue_valid=1 and issue_ready=0 (AXI-style hold).
- cfg_pending is set by cfg_update in any state. A cfg_update in the same cycle as the LOAD capture keeps cfg_pending=1 for the next frame.
- inflight accounting:
  - +1 on transfer, -1 on retire.
  - Simultaneous transfer and retire: unchanged.
  - Retire at inflight==0: count held at 0 and retire_err set; cleared only by reset.
- Credit limit: at inflight==MAX_INFLIGHT, issue_valid drops in the same cycle it is computed; no issue beyond the limit ever occurs.
- enable deasserted mid-frame: the current frame completes (ISSUE and DRAIN), then the block goes to IDLE. No partial frames.
- Reset mid-frame: everything clears immediately. Rays already in flight that retire after reset set retire_err; software resets the ray unit together with this block.
- Latency: enable rise -> first issue_valid = 2 cycles (IDLE->LOAD->ISSUE). Last transfer -> frame_done >= 1 cycle.

Optional Feature:
- Macro: RAY_SCHED_PERF_EN.
- When defined, three extra outputs are added:
  - frame_cycles [31:0]: cycles from LOAD to frame_done.
  - stall_credit [31:0]: ISSUE cycles with inflight==MAX_INFLIGHT.
  - stall_ready [31:0]: ISSUE cycles with issue_valid=1 and issue_ready=0.
  - Counters saturate at 0xFFFFFFFF, clear on entry to LOAD, and hold after frame_done until the next LOAD.
- When not defined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- SCREEN_W=4, SCREEN_H=2, issue_ready=1, retire 3 cycles after each issue -> 8 transfers; screen_x sequence 0,0x200000,0x400000,0x600000 per line; issue_sof on the first transfer only; issue_eol on transfers 4 and 8; one frame_done after the 8th retire.
- MAX_INFLIGHT=4, retire held 0 -> exactly 4 transfers, inflight=4, issue_valid=0. One retire pulse -> exactly one further transfer.
- Simultaneous transfer and retire at inflight=2 -> inflight stays 2. Retire at inflight=0 -> retire_err=1, inflight=0.
- cfg_in=A at reset, enable=1. During frame 1, cfg_in=B with cfg_update pulse -> cfg_out=A for all of frame 1 and becomes B in the LOAD cycle of frame 2.
- issue_ready toggled randomly -> screen_x/screen_y held during stalls, no pixel skipped or duplicated (scoreboard covers full raster). enable dropped mid-frame -> frame completes, busy falls after frame_done.
- periph_reset asserted mid-ISSUE -> all outputs 0 asynchronously. After release with enable=1, the next frame starts at (0,0) with issue_sof=1.
